// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: pipeline stall/flush handshake bundle between the pipeline and its sequencer
// master: the pipeline side (drives requests, receives hold/flush controls)
// slave : the sequencer side (pipe_stall_ctrl)
interface pipe_stall_ctrl_if #(parameter int ADDR_W = 32);
   logic              stallreq_id;
   logic              stallreq_ex;
   logic              ex_div_start;
   logic              flush_req;
   logic [ADDR_W-1:0] exc_pc;
   logic [5:0]        stall;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic              div_busy;
   logic              div_done;
   logic [31:0]       stall_cycles;
   modport master (
      output stallreq_id, stallreq_ex, ex_div_start, flush_req, exc_pc,
      input  stall, flush, new_pc, div_busy, div_done, stall_cycles
   );
   modport slave (
      input  stallreq_id, stallreq_ex, ex_div_start, flush_req, exc_pc,
      output stall, flush, new_pc, div_busy, div_done, stall_cycles
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: 5-stage pipeline sequencer (stall vector, one-cycle flush, divider stall window)
// Ports: clk, rst (sync, active-high), bus (pipe_stall_ctrl_if.slave)
//   in : stallreq_id, stallreq_ex, ex_div_start, flush_req, exc_pc
//   out: stall[5:0] (thermometer hold, [0]=PC), flush, new_pc, div_busy, div_done, stall_cycles
// Optional macro PIPE_CTRL_PERF_EN: enables the saturating stall_cycles counter (else tied to 0).
module pipe_stall_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int ADDR_W     = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_stall_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {RUN, DIV, FLUSH} state_t;
   localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);
   if (DIV_CYCLES < 2 || DIV_CYCLES > 255) begin : g_bad_div
      $error("pipe_stall_ctrl: DIV_CYCLES must be 2..255");
   end
   state_t            state_q, state_d;
   logic [7:0]        div_cnt_q, div_cnt_d;
   logic [ADDR_W-1:0] new_pc_q, new_pc_d;
   logic [5:0]        stall;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         div_cnt_q <= '0;
         new_pc_q  <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         new_pc_q  <= new_pc_d;
      end
   end
   // flush_req wins from every state; it also cancels an in-flight divide
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      new_pc_d  = new_pc_q;
      if (bus.flush_req) begin
         state_d   = FLUSH;
         new_pc_d  = bus.exc_pc;
         div_cnt_d = '0;
      end else begin
         unique case (state_q)
            RUN: if (bus.ex_div_start) begin
               state_d   = DIV;
               div_cnt_d = DIV_LAST;
            end
            DIV: if (div_cnt_q == '0) state_d = RUN;
                 else div_cnt_d = div_cnt_q - 8'd1;
            default: state_d = RUN;
         endcase
      end
   end
   // EX stays held through the last divider cycle; the window ends on the following cycle
   always_comb begin
      stall = (state_q == FLUSH || bus.flush_req) ? 6'b000000 :
              (state_q == DIV || bus.ex_div_start || bus.stallreq_ex) ? 6'b001111 :
              bus.stallreq_id ? 6'b000111 : 6'b000000;
      bus.stall    = stall;
      bus.flush    = state_q == FLUSH;
      bus.new_pc   = new_pc_q;
      bus.div_busy = state_q == DIV;
      bus.div_done = state_q == DIV && div_cnt_q == '0 && !bus.flush_req;
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   always_ff @(posedge clk) begin
      if (rst) stall_cycles_q <= '0;
      else if (stall != '0 && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
   end
   assign bus.stall_cycles = stall_cycles_q;
`else
   assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scoreboard bench for pipe_stall_ctrl (DIV_CYCLES=4)
module tb_pipe_stall_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;
   int   step_no = 0;
   logic [31:0] perf_exp = '0;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] npc;
      logic        busy;
      logic        done;
      logic [31:0] perf;
   } exp_t;
   exp_t sb[$];
   pipe_stall_ctrl_if #(.ADDR_W(32)) bus ();
   pipe_stall_ctrl #(.DIV_CYCLES(4), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL step %0d %s: got %0h expected %0h", step_no, tag, obs, exp);
      end
   endtask
   task automatic step(input logic r, id, ex, dv, fr, input logic [31:0] pc,
                       input logic [5:0] es, input logic ef, input logic [31:0] en,
                       input logic eb, ed);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      bus.stallreq_id = id;
      bus.stallreq_ex = ex;
      bus.ex_div_start = dv;
      bus.flush_req = fr;
      bus.exc_pc = pc;
      e.stall = es;
      e.flush = ef;
      e.npc = en;
      e.busy = eb;
      e.done = ed;
      e.perf = PERF ? perf_exp : 32'h0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk("stall", 64'(bus.stall), 64'(e.stall));
      chk("flush", 64'(bus.flush), 64'(e.flush));
      chk("new_pc", 64'(bus.new_pc), 64'(e.npc));
      chk("div_busy", 64'(bus.div_busy), 64'(e.busy));
      chk("div_done", 64'(bus.div_done), 64'(e.done));
      chk("stall_cycles", 64'(bus.stall_cycles), 64'(e.perf));
      perf_exp = r ? 32'h0 : perf_exp + ((es != 6'b0) ? 32'd1 : 32'd0);
      step_no++;
   endtask
   initial begin
      bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.ex_div_start = 0; bus.flush_req = 0; bus.exc_pc = '0;
      // reset
      step(1,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      step(1,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      // load-use and EX stalls
      step(0,1,0,0,0,32'h0,   6'b000111,0,32'h0,0,0);
      step(0,1,1,0,0,32'h0,   6'b001111,0,32'h0,0,0);
      step(0,0,1,0,0,32'h0,   6'b001111,0,32'h0,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      // divide, with requests and a second start ignored inside the window
      step(0,0,0,1,0,32'h0,   6'b001111,0,32'h0,0,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h0,1,0);
      step(0,1,0,0,0,32'h0,   6'b001111,0,32'h0,1,0);
      step(0,0,1,1,0,32'h0,   6'b001111,0,32'h0,1,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h0,1,1);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      // divide cancelled by flush
      step(0,0,0,1,0,32'h0,   6'b001111,0,32'h0,0,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h0,1,0);
      step(0,0,0,0,1,32'h180, 6'b000000,0,32'h0,1,0);
      step(0,1,0,1,0,32'h0,   6'b000000,1,32'h180,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h180,0,0);
      // back-to-back flush, flush beats stallreq_ex
      step(0,0,1,0,1,32'h180, 6'b000000,0,32'h180,0,0);
      step(0,0,0,0,1,32'h200, 6'b000000,1,32'h180,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,1,32'h200,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h200,0,0);
      // flush on the last divider cycle suppresses div_done
      step(0,0,0,1,0,32'h0,   6'b001111,0,32'h200,0,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h200,1,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h200,1,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h200,1,0);
      step(0,0,0,0,1,32'h300, 6'b000000,0,32'h200,1,0);
      step(0,0,0,0,0,32'h0,   6'b000000,1,32'h300,0,0);
      // reset during a divide drops it and clears new_pc / counter
      step(0,0,0,1,0,32'h0,   6'b001111,0,32'h300,0,0);
      step(0,0,0,0,0,32'h0,   6'b001111,0,32'h300,1,0);
      step(1,0,0,0,0,32'h0,   6'b001111,0,32'h300,1,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      step(0,1,0,0,0,32'h0,   6'b000111,0,32'h0,0,0);
      step(0,0,0,0,0,32'h0,   6'b000000,0,32'h0,0,0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
